// File: rtl/regfile_write_arb.sv
// Three-requester register-file write arbiter (ALU, load, debug) with round-robin
// or ALU-priority selection, r15 write protection and a completed-write counter.
module regfile_write_arb #(
    parameter int unsigned ALU_PRIO = 0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        alu_req,
    input  logic [3:0]  alu_addr,
    input  logic [15:0] alu_data,
    output logic        alu_ack,
    input  logic        ld_req,
    input  logic [3:0]  ld_addr,
    input  logic [15:0] ld_data,
    output logic        ld_ack,
    input  logic        dbg_req,
    input  logic [3:0]  dbg_addr,
    input  logic [15:0] dbg_data,
    output logic        dbg_ack,
    output logic [15:0] reg_en,
    output logic [15:0] reg_wdata,
    output logic        err_ro,
    output logic [15:0] wr_count
);

    typedef enum logic [1:0] {
        REQ_ALU = 2'd0,
        REQ_LD  = 2'd1,
        REQ_DBG = 2'd2
    } req_e;

    req_e        last_q, last_d;
    logic [2:0]  ack_q, ack_d;
    logic [15:0] reg_en_q, reg_en_d;
    logic [15:0] reg_wdata_q, reg_wdata_d;
    logic        err_ro_q, err_ro_d;
    logic [15:0] wr_count_q, wr_count_d;

    logic [2:0]  req;
    logic [2:0]  elig;
    logic        gnt_vld;
    req_e        gnt_idx;
    req_e        cand1, cand2;
    logic [3:0]  sel_addr;
    logic [15:0] sel_data;

    function automatic req_e succ(input req_e r);
        case (r)
            REQ_ALU: succ = REQ_LD;
            REQ_LD:  succ = REQ_DBG;
            default: succ = REQ_ALU;
        endcase
    endfunction

    // A requester whose ack is showing this cycle is still holding its old
    // request, so it is masked to avoid a duplicate write.
    assign req  = {dbg_req, ld_req, alu_req};
    assign elig = req & ~ack_q;

    always_comb begin
        gnt_vld = 1'b0;
        gnt_idx = REQ_ALU;
        cand1   = succ(last_q);
        cand2   = succ(cand1);
        if (ALU_PRIO != 0 && elig[REQ_ALU]) begin
            gnt_vld = 1'b1;
            gnt_idx = REQ_ALU;
        end else if (elig[cand1]) begin
            gnt_vld = 1'b1;
            gnt_idx = cand1;
        end else if (elig[cand2]) begin
            gnt_vld = 1'b1;
            gnt_idx = cand2;
        end else if (elig[last_q]) begin
            gnt_vld = 1'b1;
            gnt_idx = last_q;
        end
    end

    always_comb begin
        case (gnt_idx)
            REQ_LD: begin
                sel_addr = ld_addr;
                sel_data = ld_data;
            end
            REQ_DBG: begin
                sel_addr = dbg_addr;
                sel_data = dbg_data;
            end
            default: begin
                sel_addr = alu_addr;
                sel_data = alu_data;
            end
        endcase
    end

    always_comb begin
        ack_d       = '0;
        reg_en_d    = '0;
        err_ro_d    = 1'b0;
        reg_wdata_d = reg_wdata_q;
        wr_count_d  = wr_count_q;
        last_d      = last_q;
        if (gnt_vld) begin
            ack_d[gnt_idx] = 1'b1;
            reg_wdata_d    = sel_data;
            last_d         = gnt_idx;
            if (sel_addr == 4'hF) begin
                err_ro_d = 1'b1;
            end else begin
                reg_en_d   = 16'h0001 << sel_addr;
                wr_count_d = wr_count_q + 16'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            last_q      <= REQ_DBG;
            ack_q       <= '0;
            reg_en_q    <= '0;
            reg_wdata_q <= '0;
            err_ro_q    <= 1'b0;
            wr_count_q  <= '0;
        end else begin
            last_q      <= last_d;
            ack_q       <= ack_d;
            reg_en_q    <= reg_en_d;
            reg_wdata_q <= reg_wdata_d;
            err_ro_q    <= err_ro_d;
            wr_count_q  <= wr_count_d;
        end
    end

    assign alu_ack   = ack_q[REQ_ALU];
    assign ld_ack    = ack_q[REQ_LD];
    assign dbg_ack   = ack_q[REQ_DBG];
    assign reg_en    = reg_en_q;
    assign reg_wdata = reg_wdata_q;
    assign err_ro    = err_ro_q;
    assign wr_count  = wr_count_q;

endmodule

// File: tb/tb_regfile_write_arb.sv
// Directed bench for regfile_write_arb: instance a uses round-robin, instance b
// uses ALU priority; inputs change on the falling edge, outputs sampled there too.
module tb_regfile_write_arb;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    logic        a_alu_req, a_ld_req, a_dbg_req;
    logic [3:0]  a_alu_addr, a_ld_addr, a_dbg_addr;
    logic [15:0] a_alu_data, a_ld_data, a_dbg_data;
    logic        a_alu_ack, a_ld_ack, a_dbg_ack, a_err;
    logic [15:0] a_en, a_wdata, a_cnt;

    logic        b_alu_req, b_ld_req, b_dbg_req;
    logic [3:0]  b_alu_addr, b_ld_addr, b_dbg_addr;
    logic [15:0] b_alu_data, b_ld_data, b_dbg_data;
    logic        b_alu_ack, b_ld_ack, b_dbg_ack, b_err;
    logic [15:0] b_en, b_wdata, b_cnt;

    int passed = 0;
    int total  = 0;

    regfile_write_arb #(.ALU_PRIO(0)) dut_a (
        .clk(clk), .reset(reset),
        .alu_req(a_alu_req), .alu_addr(a_alu_addr), .alu_data(a_alu_data), .alu_ack(a_alu_ack),
        .ld_req(a_ld_req), .ld_addr(a_ld_addr), .ld_data(a_ld_data), .ld_ack(a_ld_ack),
        .dbg_req(a_dbg_req), .dbg_addr(a_dbg_addr), .dbg_data(a_dbg_data), .dbg_ack(a_dbg_ack),
        .reg_en(a_en), .reg_wdata(a_wdata), .err_ro(a_err), .wr_count(a_cnt)
    );

    regfile_write_arb #(.ALU_PRIO(1)) dut_b (
        .clk(clk), .reset(reset),
        .alu_req(b_alu_req), .alu_addr(b_alu_addr), .alu_data(b_alu_data), .alu_ack(b_alu_ack),
        .ld_req(b_ld_req), .ld_addr(b_ld_addr), .ld_data(b_ld_data), .ld_ack(b_ld_ack),
        .dbg_req(b_dbg_req), .dbg_addr(b_dbg_addr), .dbg_data(b_dbg_data), .dbg_ack(b_dbg_ack),
        .reg_en(b_en), .reg_wdata(b_wdata), .err_ro(b_err), .wr_count(b_cnt)
    );

    task automatic idle_inputs();
        a_alu_req = 0; a_ld_req = 0; a_dbg_req = 0;
        a_alu_addr = 0; a_ld_addr = 0; a_dbg_addr = 0;
        a_alu_data = 0; a_ld_data = 0; a_dbg_data = 0;
        b_alu_req = 0; b_ld_req = 0; b_dbg_req = 0;
        b_alu_addr = 0; b_ld_addr = 0; b_dbg_addr = 0;
        b_alu_data = 0; b_ld_data = 0; b_dbg_data = 0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        idle_inputs();
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_reset();
        idle_inputs();
        reset = 1'b0;
        #2;
        total++; if (a_en !== 16'h0 || a_wdata !== 16'h0) $display("FAIL reset_bus en=%h wdata=%h exp 0000/0000", a_en, a_wdata); else passed++;
        total++; if ({a_alu_ack, a_ld_ack, a_dbg_ack, a_err} !== 4'b0) $display("FAIL reset_acks got %b exp 0000", {a_alu_ack, a_ld_ack, a_dbg_ack, a_err}); else passed++;
        total++; if (a_cnt !== 16'h0 || b_cnt !== 16'h0) $display("FAIL reset_count a=%h b=%h exp 0000", a_cnt, b_cnt); else passed++;
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_single_write();
        a_alu_req = 1; a_alu_addr = 4'd3; a_alu_data = 16'h1234;
        @(negedge clk);
        total++; if (a_en !== 16'h0008) $display("FAIL single_en got %h exp 0008", a_en); else passed++;
        total++; if (a_wdata !== 16'h1234) $display("FAIL single_wdata got %h exp 1234", a_wdata); else passed++;
        total++; if (a_alu_ack !== 1'b1 || a_ld_ack !== 1'b0 || a_dbg_ack !== 1'b0) $display("FAIL single_ack got %b exp 100", {a_alu_ack, a_ld_ack, a_dbg_ack}); else passed++;
        total++; if (a_cnt !== 16'd1) $display("FAIL single_count got %0d exp 1", a_cnt); else passed++;
        a_alu_req = 0;
        @(negedge clk);
        total++; if (a_en !== 16'h0 || a_alu_ack !== 1'b0) $display("FAIL idle_after en=%h ack=%b exp 0000/0", a_en, a_alu_ack); else passed++;
        total++; if (a_wdata !== 16'h1234) $display("FAIL idle_wdata_hold got %h exp 1234", a_wdata); else passed++;
    endtask

    task automatic test_contention();
        do_reset();
        a_alu_req = 1; a_alu_addr = 4'd1; a_alu_data = 16'hA001;
        a_ld_req  = 1; a_ld_addr  = 4'd2; a_ld_data  = 16'hB002;
        a_dbg_req = 1; a_dbg_addr = 4'd4; a_dbg_data = 16'hC004;
        @(negedge clk);
        total++; if ({a_alu_ack, a_ld_ack, a_dbg_ack} !== 3'b100 || a_en !== 16'h0002) $display("FAIL rr_first acks=%b en=%h exp 100/0002", {a_alu_ack, a_ld_ack, a_dbg_ack}, a_en); else passed++;
        a_alu_req = 0;
        @(negedge clk);
        total++; if ({a_alu_ack, a_ld_ack, a_dbg_ack} !== 3'b010 || a_en !== 16'h0004) $display("FAIL rr_second acks=%b en=%h exp 010/0004", {a_alu_ack, a_ld_ack, a_dbg_ack}, a_en); else passed++;
        a_ld_req = 0;
        @(negedge clk);
        total++; if ({a_alu_ack, a_ld_ack, a_dbg_ack} !== 3'b001 || a_en !== 16'h0010 || a_wdata !== 16'hC004) $display("FAIL rr_third acks=%b en=%h wd=%h exp 001/0010/C004", {a_alu_ack, a_ld_ack, a_dbg_ack}, a_en, a_wdata); else passed++;
        a_dbg_req = 0;
        @(negedge clk);
        total++; if (a_cnt !== 16'd3) $display("FAIL rr_count got %0d exp 3", a_cnt); else passed++;
    endtask

    task automatic test_read_only();
        a_dbg_req = 1; a_dbg_addr = 4'd15; a_dbg_data = 16'hBEEF;
        @(negedge clk);
        a_dbg_req = 0;
        total++; if (a_dbg_ack !== 1'b1 || a_err !== 1'b1) $display("FAIL r15_ack_err ack=%b err=%b exp 1/1", a_dbg_ack, a_err); else passed++;
        total++; if (a_en !== 16'h0) $display("FAIL r15_en got %h exp 0000", a_en); else passed++;
        total++; if (a_cnt !== 16'd3) $display("FAIL r15_count got %0d exp 3", a_cnt); else passed++;
        @(negedge clk);
        total++; if (a_err !== 1'b0) $display("FAIL r15_err_pulse got %b exp 0", a_err); else passed++;
    endtask

    task automatic test_alu_prio();
        // Expected grant sequence with ALU priority: alu, ld, alu, ld, alu, ld (dbg starves).
        logic [2:0]  exp_ack [6] = '{3'b100, 3'b010, 3'b100, 3'b010, 3'b100, 3'b010};
        logic [15:0] exp_en  [6] = '{16'h0020, 16'h0100, 16'h0040, 16'h0100, 16'h0080, 16'h0100};
        do_reset();
        b_alu_req = 1; b_alu_addr = 4'd5; b_alu_data = 16'h0005;
        b_ld_req  = 1; b_ld_addr  = 4'd8; b_ld_data  = 16'h0008;
        b_dbg_req = 1; b_dbg_addr = 4'd9; b_dbg_data = 16'h0009;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            total++; if ({b_alu_ack, b_ld_ack, b_dbg_ack} !== exp_ack[i] || b_en !== exp_en[i]) $display("FAIL prio_step%0d acks=%b en=%h exp %b/%h", i, {b_alu_ack, b_ld_ack, b_dbg_ack}, b_en, exp_ack[i], exp_en[i]); else passed++;
            if (b_alu_ack) begin
                b_alu_addr = b_alu_addr + 4'd1;
                b_alu_data = b_alu_data + 16'd1;
            end
        end
        b_alu_req = 0; b_ld_req = 0; b_dbg_req = 0;
        total++; if (b_cnt !== 16'd6) $display("FAIL prio_count got %0d exp 6", b_cnt); else passed++;
    endtask

    task automatic test_reset_mid_grant();
        do_reset();
        a_ld_req = 1; a_ld_addr = 4'd5; a_ld_data = 16'h5555;
        @(negedge clk);
        total++; if (a_ld_ack !== 1'b1 || a_en !== 16'h0020) $display("FAIL midrst_pre ack=%b en=%h exp 1/0020", a_ld_ack, a_en); else passed++;
        #1 reset = 1'b0;
        #1;
        total++; if (a_en !== 16'h0 || a_ld_ack !== 1'b0 || a_cnt !== 16'h0) $display("FAIL midrst_async en=%h ack=%b cnt=%h exp 0000/0/0000", a_en, a_ld_ack, a_cnt); else passed++;
        @(negedge clk);
        reset = 1'b1;
        a_alu_req = 1; a_alu_addr = 4'd1; a_alu_data = 16'h1111;
        @(negedge clk);
        total++; if ({a_alu_ack, a_ld_ack, a_dbg_ack} !== 3'b100 || a_en !== 16'h0002) $display("FAIL midrst_resume acks=%b en=%h exp 100/0002", {a_alu_ack, a_ld_ack, a_dbg_ack}, a_en); else passed++;
        a_alu_req = 0; a_ld_req = 0;
        @(negedge clk);
    endtask

    task automatic test_wrap();
        int acks = 0;
        int cycles = 0;
        do_reset();
        a_alu_req = 1; a_alu_addr = 4'd1; a_alu_data = 16'h0101;
        a_ld_req  = 1; a_ld_addr  = 4'd2; a_ld_data  = 16'h0202;
        while (acks < 65535 && cycles < 70000) begin
            @(negedge clk);
            cycles++;
            if (a_alu_ack || a_ld_ack) acks++;
        end
        a_alu_req = 0; a_ld_req = 0;
        total++; if (acks != 65535) $display("FAIL wrap_timeout acks=%0d exp 65535", acks); else passed++;
        total++; if (a_cnt !== 16'hFFFF) $display("FAIL wrap_full got %h exp FFFF", a_cnt); else passed++;
        @(negedge clk);
        a_alu_req = 1; a_alu_addr = 4'd3;
        @(negedge clk);
        a_alu_req = 0;
        total++; if (a_alu_ack !== 1'b1 || a_cnt !== 16'h0000) $display("FAIL wrap_zero ack=%b cnt=%h exp 1/0000", a_alu_ack, a_cnt); else passed++;
    endtask

    always @(negedge clk) begin
        if (reset && ((a_en & (a_en - 16'd1)) != 16'h0 || $countones({a_alu_ack, a_ld_ack, a_dbg_ack}) > 1)) begin
            total++;
            $display("FAIL onehot en=%h acks=%b exp one-hot", a_en, {a_alu_ack, a_ld_ack, a_dbg_ack});
        end
    end

    initial begin
        test_reset();
        test_single_write();
        test_contention();
        test_read_only();
        test_alu_prio();
        test_reset_mid_grant();
        test_wrap();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
